// File: rtl/rs_multi_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_multi_issue_pkg
//  Description : Shared types for the multi-issue reservation station:
//                functional-unit classes and the dispatched packet layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_multi_issue_pkg;

   localparam int DEFAULT_PREG_IDX_W = 6;
   localparam int PAYLOAD_W          = 32;

   // Functional-unit classes; FUNIT_COUNT must track the enum members.
   typedef enum logic [1:0] {
      FU_ALU   = 2'd0,
      FU_LOAD  = 2'd1,
      FU_STORE = 2'd2,
      FU_MULT  = 2'd3
   } FUNIT;

   localparam int FUNIT_COUNT = 4;

   typedef struct packed {
      FUNIT                          fu;
      logic [DEFAULT_PREG_IDX_W-1:0] src1_tag;
      logic                          src1_ready;
      logic [DEFAULT_PREG_IDX_W-1:0] src2_tag;
      logic                          src2_ready;
      logic [DEFAULT_PREG_IDX_W-1:0] dest_tag;
      logic [PAYLOAD_W-1:0]          payload;
   } RS_PACKET;

   localparam int PKT_W = $bits(RS_PACKET);

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_select
//  Description : Oldest-first picker. Grants the eligible entry that no other
//                eligible entry is older than, using a flattened age matrix
//                where older[j*RS_DEPTH+i] means entry j is older than i.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_age_select #(
   parameter int RS_DEPTH = 8
) (
   input  logic [RS_DEPTH-1:0]          eligible,
   input  logic [RS_DEPTH*RS_DEPTH-1:0] older,
   output logic [RS_DEPTH-1:0]          grant,
   output logic                         grant_valid
);

   // An eligible entry wins unless some other eligible entry predates it.
   always_comb begin
      grant = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         grant[i] = eligible[i];
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (eligible[j] && older[j*RS_DEPTH + i]) begin
               grant[i] = 1'b0;
            end
         end
      end
      grant_valid = |eligible;
   end

endmodule
`default_nettype wire

// File: rtl/rs_multi_issue.sv
`default_nettype none
// ============================================================================
//  Module      : rs_multi_issue
//  Description : Shared-pool reservation station. Allocates into the lowest
//                free entry, wakes operands from CDB broadcasts and issues the
//                oldest ready entry per FU class each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_multi_issue
   import rs_multi_issue_pkg::*;
#(
   parameter int RS_DEPTH     = 8,
   parameter int CDB_WIDTH    = 2,
   parameter int NUM_FU_TYPES = FUNIT_COUNT,
   parameter int PREG_IDX_W   = DEFAULT_PREG_IDX_W
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           alloc_valid,
   input  logic [PKT_W-1:0]               alloc_packet,
   output logic                           alloc_ready,
   input  logic [CDB_WIDTH-1:0]           cdb_valid,
   input  logic [CDB_WIDTH*PREG_IDX_W-1:0] cdb_tag,
   input  logic [NUM_FU_TYPES-1:0]        fu_avail,
   output logic [NUM_FU_TYPES-1:0]        issue_valid,
   output logic [NUM_FU_TYPES*PKT_W-1:0]  issue_packet,
   input  logic                           flush,
   output logic [$clog2(RS_DEPTH):0]      free_count
);

   localparam int CNT_W = $clog2(RS_DEPTH) + 1;

   RS_PACKET                                r_entry [RS_DEPTH];
   logic [RS_DEPTH-1:0]                     r_valid;
   logic [RS_DEPTH-1:0]                     r_older [RS_DEPTH];   // r_older[j][i]: j older than i
   logic [CNT_W-1:0]                        r_free_count;

   RS_PACKET                                w_alloc_pkt;
   logic [RS_DEPTH-1:0]                     w_alloc_oh;
   logic                                    w_alloc_fire;
   logic [RS_DEPTH-1:0]                     w_s1_hit;
   logic [RS_DEPTH-1:0]                     w_s2_hit;
   logic                                    w_a1_hit;
   logic                                    w_a2_hit;
   logic [NUM_FU_TYPES-1:0][RS_DEPTH-1:0]   w_elig;
   logic [NUM_FU_TYPES-1:0][RS_DEPTH-1:0]   w_grant;
   logic [NUM_FU_TYPES-1:0]                 w_grant_v;
   logic [RS_DEPTH*RS_DEPTH-1:0]            w_older_flat;
   logic [RS_DEPTH-1:0]                     w_issue_clr;
   logic [RS_DEPTH-1:0]                     w_valid_nxt;
   logic [CNT_W-1:0]                        w_free_nxt;

   assign w_alloc_pkt  = RS_PACKET'(alloc_packet);
   assign alloc_ready  = ~&r_valid;
   assign w_alloc_fire = alloc_valid && alloc_ready && !flush;
   // Lowest clear bit of the valid vector, as a one-hot.
   assign w_alloc_oh   = ~r_valid & (r_valid + RS_DEPTH'(1));
   assign free_count   = r_free_count;

   // Match every stored and incoming source tag against the live broadcasts.
   always_comb begin
      w_s1_hit = '0;
      w_s2_hit = '0;
      w_a1_hit = 1'b0;
      w_a2_hit = 1'b0;
      for (int b = 0; b < CDB_WIDTH; b++) begin
         if (cdb_valid[b]) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (r_entry[i].src1_tag == cdb_tag[b*PREG_IDX_W +: PREG_IDX_W]) w_s1_hit[i] = 1'b1;
               if (r_entry[i].src2_tag == cdb_tag[b*PREG_IDX_W +: PREG_IDX_W]) w_s2_hit[i] = 1'b1;
            end
            if (w_alloc_pkt.src1_tag == cdb_tag[b*PREG_IDX_W +: PREG_IDX_W]) w_a1_hit = 1'b1;
            if (w_alloc_pkt.src2_tag == cdb_tag[b*PREG_IDX_W +: PREG_IDX_W]) w_a2_hit = 1'b1;
         end
      end
   end

   // Per-class eligibility from registered state only, plus flattened ages.
   always_comb begin
      w_elig       = '0;
      w_older_flat = '0;
      for (int c = 0; c < NUM_FU_TYPES; c++) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            w_elig[c][i] = r_valid[i] && r_entry[i].src1_ready && r_entry[i].src2_ready &&
                           fu_avail[r_entry[i].fu] && (int'(r_entry[i].fu) == c);
         end
      end
      for (int j = 0; j < RS_DEPTH; j++) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            w_older_flat[j*RS_DEPTH + i] = r_older[j][i];
         end
      end
   end

   for (genvar c = 0; c < NUM_FU_TYPES; c++) begin : g_sel
      rs_age_select #(
         .RS_DEPTH    (RS_DEPTH)
      ) u_age_select (
         .eligible    (w_elig[c]),
         .older       (w_older_flat),
         .grant       (w_grant[c]),
         .grant_valid (w_grant_v[c])
      );
   end

   // Drive each class's winner onto its port; flush suppresses all issue.
   always_comb begin
      issue_valid  = '0;
      issue_packet = '0;
      w_issue_clr  = '0;
      for (int c = 0; c < NUM_FU_TYPES; c++) begin
         if (w_grant_v[c] && !flush) begin
            issue_valid[c] = 1'b1;
            w_issue_clr    = w_issue_clr | w_grant[c];
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (w_grant[c][i]) issue_packet[c*PKT_W +: PKT_W] = r_entry[i];
            end
         end
      end
   end

   // Next occupancy and the free-entry count derived from it.
   always_comb begin
      w_valid_nxt = (r_valid & ~w_issue_clr) | (w_alloc_fire ? w_alloc_oh : '0);
      if (flush) w_valid_nxt = '0;
      w_free_nxt = CNT_W'(RS_DEPTH);
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_free_nxt = w_free_nxt - CNT_W'(w_valid_nxt[i]);
      end
   end

   // Occupancy, free count and age ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid      <= '0;
         r_free_count <= CNT_W'(RS_DEPTH);
         for (int i = 0; i < RS_DEPTH; i++) r_older[i] <= '0;
      end else begin
         r_valid      <= w_valid_nxt;
         r_free_count <= w_free_nxt;
         if (w_alloc_fire) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
               if (w_alloc_oh[k]) begin
                  for (int j = 0; j < RS_DEPTH; j++) r_older[j][k] <= r_valid[j];
                  r_older[k] <= '0;
               end
            end
         end
      end
   end

   // Entry payloads: capture on allocate (with same-cycle wakeup), else wake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RS_DEPTH; i++) r_entry[i] <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_alloc_fire && w_alloc_oh[i]) begin
               r_entry[i]            <= w_alloc_pkt;
               r_entry[i].src1_ready <= w_alloc_pkt.src1_ready | w_a1_hit;
               r_entry[i].src2_ready <= w_alloc_pkt.src2_ready | w_a2_hit;
            end else begin
               if (w_s1_hit[i]) r_entry[i].src1_ready <= 1'b1;
               if (w_s2_hit[i]) r_entry[i].src2_ready <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
